usb_hub_upstream_arbiter: RTL and testbench

Round-robin scheduler that shares the single upstream host transmit path (host_tx_plus/host_tx_minus) among the NUM_USB_DEVICES downstream ports of the hub top level. Each downstream port engine raises a request when it has a packet to forward upstream. The arbiter grants one port at a time and holds the grant until end-of-packet. It enforces an inter-packet gap and cuts off babbling ports with a per-packet cycle limit. Runs on hi_clock.

---
 rtl/usb_hub_upstream_arbiter_pkg.sv | 21 ++
 rtl/usb_hub_upstream_arbiter_if.sv | 33 +++
 rtl/usb_hub_upstream_arbiter_rr_picker.sv | 36 +++
 rtl/usb_hub_upstream_arbiter.sv | 144 ++++++++++++++
 tb/tb_usb_hub_upstream_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_hub_upstream_arbiter_pkg.sv
// Shared types and constants for the USB hub upstream path and port-control blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package usb_hub_pkg;

    localparam int ARB_STATE_W            = 2;
    localparam int DEFAULT_MAX_PKT_CYCLES = 4096;
    localparam int DEFAULT_IPG_CYCLES     = 8;

    typedef enum logic [ARB_STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    // Width of a port index; a single-port hub still carries a 1-bit index.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/usb_hub_upstream_arbiter_if.sv
// Request/grant bundle between the downstream port engines and the upstream arbiter.
// Latency: n/a (wires only).
// Backpressure: grant is the only flow control; a port may drive upstream only while granted.
// Ports: port_enable/req/eop/clear_babble per port, host_busy; grant/grant_valid/grant_idx/babble back.
interface usb_hub_upstream_arbiter_if
    import usb_hub_pkg::*;
#(
    parameter int NUM_USB_DEVICES = 4
) ();
    localparam int IDX_W = idx_width(NUM_USB_DEVICES);

    logic [NUM_USB_DEVICES-1:0] port_enable;
    logic [NUM_USB_DEVICES-1:0] req;
    logic [NUM_USB_DEVICES-1:0] eop;
    logic                       host_busy;
    logic [NUM_USB_DEVICES-1:0] clear_babble;
    logic [NUM_USB_DEVICES-1:0] grant;
    logic                       grant_valid;
    logic [IDX_W-1:0]           grant_idx;
    logic [NUM_USB_DEVICES-1:0] babble;

    // Arbiter side.
    modport slave (
        input  port_enable, req, eop, host_busy, clear_babble,
        output grant, grant_valid, grant_idx, babble
    );

    // Port-engine / hub-control side.
    modport master (
        output port_enable, req, eop, host_busy, clear_babble,
        input  grant, grant_valid, grant_idx, babble
    );
endinterface

// File: rtl/usb_hub_upstream_arbiter_rr_picker.sv
// Round-robin search: first set bit of eligible at or above ptr, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; found=0 when nothing is eligible.
// Ports: eligible, ptr in; found, onehot, idx out.
module usb_hub_rr_picker #(
    parameter int NUM   = 4,
    parameter int IDX_W = 2
) (
    input  logic [NUM-1:0]   eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [NUM-1:0]   onehot,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        int pos;
        pos    = 0;
        found  = 1'b0;
        onehot = '0;
        idx    = '0;
        for (int k = 0; k < NUM; k++) begin
            // ptr is always < NUM, so one subtraction covers the wrap.
            pos = int'(ptr) + k;
            if (pos >= NUM) begin
                pos = pos - NUM;
            end
            if (!found && eligible[pos]) begin
                found       = 1'b1;
                onehot[pos] = 1'b1;
                idx         = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/usb_hub_upstream_arbiter.sv
// Round-robin owner of the upstream transmit path: one port at a time, held to end-of-packet.
// Latency: request sampled at an edge is granted at that edge (registered grant); gap of IPG+1 idle cycles.
// Backpressure: host_busy holds off new grants; babbling ports are cut off and excluded until cleared.
// Ports: hi_clock, reset (async, active-high), bus (slave modport of usb_hub_upstream_arbiter_if).
module usb_hub_upstream_arbiter
    import usb_hub_pkg::*;
#(
    parameter int NUM_USB_DEVICES = 4,
    parameter int MAX_PKT_CYCLES  = DEFAULT_MAX_PKT_CYCLES,
    parameter int IPG_CYCLES      = DEFAULT_IPG_CYCLES
) (
    input  logic                       hi_clock,
    input  logic                       reset,
    usb_hub_upstream_arbiter_if.slave  bus
);

    localparam int N       = NUM_USB_DEVICES;
    localparam int IDX_W   = idx_width(N);
    localparam int CNT_W   = $clog2(MAX_PKT_CYCLES) + 1;
    localparam int GAP_LEN = (IPG_CYCLES < 1) ? 1 : IPG_CYCLES;
    localparam int GAP_W   = $clog2(GAP_LEN) + 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PKT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [N-1:0]     grant_q, grant_d;
    logic             grant_vld_q, grant_vld_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [N-1:0]     babble_q, babble_d;

    logic [N-1:0]     eligible;
    logic             pick_found;
    logic [N-1:0]     pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             gnt_eop;
    logic             gnt_abort;
    logic [IDX_W-1:0] next_ptr;

    assign eligible = bus.req & bus.port_enable & ~babble_q;

    // Masking with the one-hot grant avoids indexing by grant_idx and ignores other ports' eop.
    assign gnt_eop   = |(bus.eop & grant_q);
    assign gnt_abort = ~|(bus.port_enable & grant_q);
    assign next_ptr  = (grant_idx_q == IDX_LAST) ? '0 : grant_idx_q + IDX_W'(1);

    usb_hub_rr_picker #(
        .NUM   (N),
        .IDX_W (IDX_W)
    ) u_picker (
        .eligible (eligible),
        .ptr      (ptr_q),
        .found    (pick_found),
        .onehot   (pick_onehot),
        .idx      (pick_idx)
    );

    always_comb begin
        logic [N-1:0] babble_set;
        babble_set  = '0;
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        grant_d     = grant_q;
        grant_vld_d = grant_vld_q;
        grant_idx_d = grant_idx_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!bus.host_busy && pick_found) begin
                    grant_d     = pick_onehot;
                    grant_idx_d = pick_idx;
                    grant_vld_d = 1'b1;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // eop/abort take priority over the timeout, so a packet ending on
                // its last allowed cycle is not flagged as babble.
                if (gnt_eop || gnt_abort || (cnt_q == CNT_LAST)) begin
                    if (!(gnt_eop || gnt_abort)) begin
                        babble_set = grant_q;
                    end
                    grant_d     = '0;
                    grant_vld_d = 1'b0;
                    ptr_d       = next_ptr;
                    cnt_d       = '0;
                    gap_d       = '0;
                    state_d     = ST_GAP;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Set beats clear when both land on the same edge.
        babble_d = (babble_q & ~bus.clear_babble) | babble_set;
    end

    always_ff @(posedge hi_clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            grant_q     <= '0;
            grant_vld_q <= 1'b0;
            grant_idx_q <= '0;
            babble_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            grant_q     <= grant_d;
            grant_vld_q <= grant_vld_d;
            grant_idx_q <= grant_idx_d;
            babble_q    <= babble_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = grant_vld_q;
    assign bus.grant_idx   = grant_idx_q;
    assign bus.babble      = babble_q;

endmodule

// File: tb/tb_usb_hub_upstream_arbiter.sv
// Directed bench for the upstream arbiter: N=4, MAX_PKT_CYCLES=16, IPG_CYCLES=2.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled there too.
// Backpressure: every wait on the DUT is bounded by a cycle budget.
module tb_usb_hub_upstream_arbiter;

    localparam int N    = 4;
    localparam int MAXC = 16;
    localparam int IPG  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    usb_hub_upstream_arbiter_if #(.NUM_USB_DEVICES(N)) bus ();

    usb_hub_upstream_arbiter #(
        .NUM_USB_DEVICES (N),
        .MAX_PKT_CYCLES  (MAXC),
        .IPG_CYCLES      (IPG)
    ) dut (
        .hi_clock (clk),
        .reset    (rst),
        .bus      (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles until grant_valid rises (0 if already high); ok=0 if the budget ran out.
    task automatic wait_grant(output int cyc, output bit ok);
        cyc = 0;
        while (!bus.grant_valid && cyc < 50) begin
            cyc++;
            tick();
        end
        ok = bus.grant_valid;
    endtask

    task automatic pulse_eop(input logic [N-1:0] v);
        bus.eop = v;
        tick();
        bus.eop = '0;
    endtask

    task automatic test_reset();
        bus.port_enable  = 4'b1111;
        bus.req          = '0;
        bus.eop          = '0;
        bus.host_busy    = 1'b0;
        bus.clear_babble = '0;
        rst              = 1'b1;
        #2;
        n_checks++;
        if (bus.grant !== 4'b0000) begin
            n_fail++; $display("FAIL reset_grant: got %b expected 0000", bus.grant);
        end
        n_checks++;
        if (bus.grant_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.grant_valid);
        end
        n_checks++;
        if (bus.grant_idx !== 2'd0) begin
            n_fail++; $display("FAIL reset_idx: got %0d expected 0", bus.grant_idx);
        end
        n_checks++;
        if (bus.babble !== 4'b0000) begin
            n_fail++; $display("FAIL reset_babble: got %b expected 0000", bus.babble);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        int         cyc;
        bit         ok;
        int         exp_idx;
        int         exp_cyc;
        logic [3:0] exp_g;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_idx = k % 4;
            exp_g   = 4'b0001 << exp_idx;
            exp_cyc = (k == 0) ? 1 : 3;
            wait_grant(cyc, ok);
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL rr_timeout k=%0d: no grant after %0d cycles", k, cyc);
            end
            n_checks++;
            if (bus.grant !== exp_g) begin
                n_fail++; $display("FAIL rr_grant k=%0d: got %b expected %b", k, bus.grant, exp_g);
            end
            n_checks++;
            if (bus.grant_idx !== 2'(exp_idx)) begin
                n_fail++; $display("FAIL rr_idx k=%0d: got %0d expected %0d", k, bus.grant_idx, exp_idx);
            end
            n_checks++;
            if (cyc != exp_cyc) begin
                n_fail++; $display("FAIL rr_gap k=%0d: got %0d idle cycles expected %0d", k, cyc, exp_cyc);
            end
            tick();
            tick();
            pulse_eop(exp_g);
            n_checks++;
            if (bus.grant !== 4'b0000) begin
                n_fail++; $display("FAIL rr_drop k=%0d: got %b expected 0000", k, bus.grant);
            end
        end
        bus.req = '0;
        repeat (5) tick();
    endtask

    task automatic test_wrap_skip();
        int cyc;
        bit ok;
        // Pointer is 1; serving port 2 moves it to 3.
        bus.req = 4'b0100;
        wait_grant(cyc, ok);
        n_checks++;
        if (bus.grant !== 4'b0100) begin
            n_fail++; $display("FAIL wrap_setup: got %b expected 0100", bus.grant);
        end
        tick();
        pulse_eop(4'b0100);
        bus.req = 4'b0101;
        wait_grant(cyc, ok);
        n_checks++;
        if (bus.grant !== 4'b0001 || cyc != 3) begin
            n_fail++; $display("FAIL wrap_port0: got %b after %0d expected 0001 after 3", bus.grant, cyc);
        end
        tick();
        pulse_eop(4'b0001);
        wait_grant(cyc, ok);
        n_checks++;
        if (bus.grant !== 4'b0100 || cyc != 3) begin
            n_fail++; $display("FAIL wrap_port2: got %b after %0d expected 0100 after 3", bus.grant, cyc);
        end
        bus.port_enable = 4'b1011;
        tick();
        n_checks++;
        if (bus.grant !== 4'b0000 || bus.babble !== 4'b0000) begin
            n_fail++; $display("FAIL abort_drop: grant %b babble %b expected 0000 0000", bus.grant, bus.babble);
        end
        bus.port_enable = 4'b1111;
        wait_grant(cyc, ok);
        n_checks++;
        if (bus.grant !== 4'b0001 || cyc != 3) begin
            n_fail++; $display("FAIL abort_next: got %b after %0d expected 0001 after 3", bus.grant, cyc);
        end
        pulse_eop(4'b0001);
        bus.req = '0;
        repeat (5) tick();
    endtask

    task automatic test_babble();
        int cyc;
        bit ok;
        int held;
        bit saw;
        bus.req = 4'b0010;
        wait_grant(cyc, ok);
        n_checks++;
        if (bus.grant !== 4'b0010) begin
            n_fail++; $display("FAIL babble_grant: got %b expected 0010", bus.grant);
        end
        held = 0;
        while (bus.grant_valid && held < 100) begin
            held++;
            tick();
        end
        n_checks++;
        if (held != MAXC) begin
            n_fail++; $display("FAIL babble_hold: got %0d cycles expected %0d", held, MAXC);
        end
        n_checks++;
        if (bus.babble !== 4'b0010) begin
            n_fail++; $display("FAIL babble_flag: got %b expected 0010", bus.babble);
        end
        saw = 1'b0;
        repeat (10) begin
            tick();
            if (bus.grant_valid) saw = 1'b1;
        end
        n_checks++;
        if (saw !== 1'b0) begin
            n_fail++; $display("FAIL babble_excluded: got grant %b expected none", saw);
        end
        bus.clear_babble = 4'b0010;
        tick();
        bus.clear_babble = '0;
        n_checks++;
        if (bus.babble !== 4'b0000) begin
            n_fail++; $display("FAIL babble_clear: got %b expected 0000", bus.babble);
        end
        wait_grant(cyc, ok);
        n_checks++;
        if (bus.grant !== 4'b0010 || cyc != 1) begin
            n_fail++; $display("FAIL babble_regrant: got %b after %0d expected 0010 after 1", bus.grant, cyc);
        end
        pulse_eop(4'b0010);
        bus.req = '0;
        repeat (5) tick();
    endtask

    task automatic test_corner_cycles();
        int cyc;
        bit ok;
        // Pointer is 2.
        bus.req = 4'b0100;
        wait_grant(cyc, ok);
        n_checks++;
        if (bus.grant !== 4'b0100) begin
            n_fail++; $display("FAIL corner_grant: got %b expected 0100", bus.grant);
        end
        repeat (MAXC - 1) tick();
        pulse_eop(4'b0100);
        n_checks++;
        if (bus.grant !== 4'b0000 || bus.babble !== 4'b0000) begin
            n_fail++; $display("FAIL eop_on_timeout: grant %b babble %b expected 0000 0000", bus.grant, bus.babble);
        end
        // Pointer is 3; search wraps 3,0,1.
        bus.req = 4'b0010;
        wait_grant(cyc, ok);
        n_checks++;
        if (bus.grant !== 4'b0010) begin
            n_fail++; $display("FAIL corner_grant1: got %b expected 0010", bus.grant);
        end
        repeat (MAXC - 1) tick();
        bus.clear_babble = 4'b0010;
        tick();
        bus.clear_babble = '0;
        n_checks++;
        if (bus.babble !== 4'b0010 || bus.grant !== 4'b0000) begin
            n_fail++; $display("FAIL set_beats_clear: babble %b grant %b expected 0010 0000", bus.babble, bus.grant);
        end
        bus.req = '0;
        bus.clear_babble = 4'b0010;
        tick();
        bus.clear_babble = '0;
        repeat (5) tick();
    endtask

    task automatic test_host_busy();
        bit saw;
        // Pointer is 2.
        bus.host_busy = 1'b1;
        bus.req       = 4'b0010;
        saw = 1'b0;
        repeat (5) begin
            tick();
            if (bus.grant_valid) saw = 1'b1;
        end
        n_checks++;
        if (saw !== 1'b0) begin
            n_fail++; $display("FAIL busy_block: got grant %b expected none", saw);
        end
        bus.host_busy = 1'b0;
        tick();
        n_checks++;
        if (bus.grant !== 4'b0010) begin
            n_fail++; $display("FAIL busy_release: got %b expected 0010", bus.grant);
        end
        bus.host_busy = 1'b1;
        saw = 1'b0;
        repeat (3) begin
            tick();
            if (bus.grant !== 4'b0010) saw = 1'b1;
        end
        n_checks++;
        if (saw !== 1'b0) begin
            n_fail++; $display("FAIL busy_in_grant: got drop %b expected grant held", saw);
        end
        bus.host_busy = 1'b0;
        pulse_eop(4'b0010);
        bus.req = '0;
        repeat (5) tick();
    endtask

    task automatic test_reset_mid_grant();
        int cyc;
        bit ok;
        int held;
        // Pointer is 2: port 0 is reached by wrap; let it babble.
        bus.req = 4'b0001;
        wait_grant(cyc, ok);
        held = 0;
        while (bus.grant_valid && held < 100) begin
            held++;
            tick();
        end
        n_checks++;
        if (bus.babble !== 4'b0001) begin
            n_fail++; $display("FAIL rst_setup_babble: got %b expected 0001", bus.babble);
        end
        bus.req = 4'b0100;
        wait_grant(cyc, ok);
        n_checks++;
        if (bus.grant !== 4'b0100) begin
            n_fail++; $display("FAIL rst_setup_grant: got %b expected 0100", bus.grant);
        end
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.grant !== 4'b0000 || bus.grant_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_async_grant: grant %b valid %b expected 0000 0", bus.grant, bus.grant_valid);
        end
        n_checks++;
        if (bus.babble !== 4'b0000 || bus.grant_idx !== 2'd0) begin
            n_fail++; $display("FAIL rst_async_state: babble %b idx %0d expected 0000 0", bus.babble, bus.grant_idx);
        end
        bus.req = 4'b1000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_grant(cyc, ok);
        n_checks++;
        if (bus.grant !== 4'b1000 || bus.grant_idx !== 2'd3 || cyc != 1) begin
            n_fail++; $display("FAIL rst_regrant: grant %b idx %0d after %0d expected 1000 3 after 1", bus.grant, bus.grant_idx, cyc);
        end
        pulse_eop(4'b1000);
        bus.req = '0;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_wrap_skip();
        test_babble();
        test_corner_cycles();
        test_host_busy();
        test_reset_mid_grant();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

endmodule
